// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: widths, opcodes, group codes and compare codes.
package alu_pkg;

    localparam int IN_WD    = 16;
    localparam int ARITH_WD = 2 * IN_WD;
    localparam int LOGIC_WD = IN_WD;
    localparam int SHIFT_WD = IN_WD;
    localparam int CMP_WD   = IN_WD;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_MUL   = 4'd2;
    localparam logic [3:0] ALU_DIV   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_OR    = 4'd5;
    localparam logic [3:0] ALU_NAND  = 4'd6;
    localparam logic [3:0] ALU_NOR   = 4'd7;
    localparam logic [3:0] ALU_NOP   = 4'd8;
    localparam logic [3:0] ALU_EQ    = 4'd9;
    localparam logic [3:0] ALU_GT    = 4'd10;
    localparam logic [3:0] ALU_LT    = 4'd11;
    localparam logic [3:0] ALU_SHR_A = 4'd12;
    localparam logic [3:0] ALU_SHL_A = 4'd13;
    localparam logic [3:0] ALU_SHR_B = 4'd14;
    localparam logic [3:0] ALU_SHL_B = 4'd15;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_CMP   = 2'b10;
    localparam logic [1:0] GRP_SHIFT = 2'b11;

    localparam logic [CMP_WD-1:0] CMP_EQ = CMP_WD'(1);
    localparam logic [CMP_WD-1:0] CMP_GT = CMP_WD'(2);
    localparam logic [CMP_WD-1:0] CMP_LT = CMP_WD'(3);

endpackage

// File: rtl/alu_arith_unit.sv
// Combinational signed add/sub/mul/div unit; carry reflects the unsigned view of the operands.
module alu_arith_unit
    import alu_pkg::*;
(
    input  logic                en,
    input  logic [3:0]          fun,
    input  logic [IN_WD-1:0]    a,
    input  logic [IN_WD-1:0]    b,
    output logic [ARITH_WD-1:0] result,
    output logic                carry
);

    logic signed [ARITH_WD-1:0] a_ext;
    logic signed [ARITH_WD-1:0] b_ext;

    assign a_ext = {{IN_WD{a[IN_WD-1]}}, a};
    assign b_ext = {{IN_WD{b[IN_WD-1]}}, b};

    // Unsigned a+b overflows exactly when a exceeds the largest value b can still be added to (~b).
    always_comb begin
        result = '0;
        carry  = 1'b0;
        if (en) begin
            case (fun)
                ALU_ADD: begin
                    result = a_ext + b_ext;
                    carry  = (a > ~b);
                end
                ALU_SUB: begin
                    result = a_ext - b_ext;
                    carry  = (a < b);
                end
                ALU_MUL: result = a_ext * b_ext;
                ALU_DIV: begin
                    if (b != '0)
                        result = a_ext / b_ext;
                end
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmp_unit.sv
// Combinational signed compare unit producing a small result code.
module alu_cmp_unit
    import alu_pkg::*;
(
    input  logic              en,
    input  logic [3:0]        fun,
    input  logic [IN_WD-1:0]  a,
    input  logic [IN_WD-1:0]  b,
    output logic [CMP_WD-1:0] result
);

    logic signed [IN_WD-1:0] sa;
    logic signed [IN_WD-1:0] sb;

    assign sa = a;
    assign sb = b;

    always_comb begin
        result = '0;
        if (en) begin
            case (fun)
                ALU_EQ:  result = (sa == sb) ? CMP_EQ : '0;
                ALU_GT:  result = (sa > sb)  ? CMP_GT : '0;
                ALU_LT:  result = (sa < sb)  ? CMP_LT : '0;
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_logic_unit.sv
// Combinational bitwise AND/OR/NAND/NOR unit.
module alu_logic_unit
    import alu_pkg::*;
(
    input  logic                en,
    input  logic [3:0]          fun,
    input  logic [IN_WD-1:0]    a,
    input  logic [IN_WD-1:0]    b,
    output logic [LOGIC_WD-1:0] result
);

    always_comb begin
        result = '0;
        if (en) begin
            case (fun)
                ALU_AND:  result = a & b;
                ALU_OR:   result = a | b;
                ALU_NAND: result = ~(a & b);
                ALU_NOR:  result = ~(a | b);
                default:  result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_shift_unit.sv
// Combinational single-bit logical shift unit with zero fill on either operand.
module alu_shift_unit
    import alu_pkg::*;
(
    input  logic                en,
    input  logic [3:0]          fun,
    input  logic [IN_WD-1:0]    a,
    input  logic [IN_WD-1:0]    b,
    output logic [SHIFT_WD-1:0] result
);

    always_comb begin
        result = '0;
        if (en) begin
            case (fun)
                ALU_SHR_A: result = a >> 1;
                ALU_SHL_A: result = a << 1;
                ALU_SHR_B: result = b >> 1;
                ALU_SHL_B: result = b << 1;
                default:   result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_top.sv
// Registered 16-bit signed ALU: group decode, four gated combinational units, one output register stage.
module alu_top
    import alu_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [IN_WD-1:0]    A,
    input  logic [IN_WD-1:0]    B,
    input  logic [3:0]          ALU_FUN,
    output logic [ARITH_WD-1:0] ARITH_OUT,
    output logic                CARRY_OUT,
    output logic [LOGIC_WD-1:0] LOGIC_OUT,
    output logic [CMP_WD-1:0]   CMP_OUT,
    output logic [SHIFT_WD-1:0] SHIFT_OUT,
    output logic                ARITH_FLAG,
    output logic                LOGIC_FLAG,
    output logic                CMP_FLAG,
    output logic                SHIFT_FLAG
);

    logic [1:0]          grp;
    logic                arith_en;
    logic                logic_en;
    logic                cmp_en;
    logic                shift_en;
    logic [ARITH_WD-1:0] arith_res;
    logic                carry_res;
    logic [LOGIC_WD-1:0] logic_res;
    logic [CMP_WD-1:0]   cmp_res;
    logic [SHIFT_WD-1:0] shift_res;

    // Exactly one enable is high; the disabled units drive zero so their buses clear.
    assign grp      = ALU_FUN[3:2];
    assign arith_en = (grp == GRP_ARITH);
    assign logic_en = (grp == GRP_LOGIC);
    assign cmp_en   = (grp == GRP_CMP);
    assign shift_en = (grp == GRP_SHIFT);

    alu_arith_unit u_arith (
        .en     (arith_en),
        .fun    (ALU_FUN),
        .a      (A),
        .b      (B),
        .result (arith_res),
        .carry  (carry_res)
    );

    alu_logic_unit u_logic (
        .en     (logic_en),
        .fun    (ALU_FUN),
        .a      (A),
        .b      (B),
        .result (logic_res)
    );

    alu_cmp_unit u_cmp (
        .en     (cmp_en),
        .fun    (ALU_FUN),
        .a      (A),
        .b      (B),
        .result (cmp_res)
    );

    alu_shift_unit u_shift (
        .en     (shift_en),
        .fun    (ALU_FUN),
        .a      (A),
        .b      (B),
        .result (shift_res)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            ARITH_OUT  <= '0;
            CARRY_OUT  <= 1'b0;
            LOGIC_OUT  <= '0;
            CMP_OUT    <= '0;
            SHIFT_OUT  <= '0;
            ARITH_FLAG <= 1'b0;
            LOGIC_FLAG <= 1'b0;
            CMP_FLAG   <= 1'b0;
            SHIFT_FLAG <= 1'b0;
        end else begin
            ARITH_OUT  <= arith_res;
            CARRY_OUT  <= carry_res;
            LOGIC_OUT  <= logic_res;
            CMP_OUT    <= cmp_res;
            SHIFT_OUT  <= shift_res;
            ARITH_FLAG <= arith_en;
            LOGIC_FLAG <= logic_en;
            CMP_FLAG   <= cmp_en;
            SHIFT_FLAG <= shift_en;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed steps then random operations against an integer reference model.
module tb_alu_top;

    typedef struct {
        logic [31:0] arith;
        logic        carry;
        logic [15:0] logic_res;
        logic [15:0] cmp;
        logic [15:0] shift;
        logic [3:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  alu_fun;
    logic [31:0] arith_out;
    logic        carry_out;
    logic [15:0] logic_out;
    logic [15:0] cmp_out;
    logic [15:0] shift_out;
    logic        arith_flag;
    logic        logic_flag;
    logic        cmp_flag;
    logic        shift_flag;

    int testCount = 0;
    int failCount = 0;

    alu_top dut (
        .CLK        (clk),
        .RST        (rst),
        .A          (a),
        .B          (b),
        .ALU_FUN    (alu_fun),
        .ARITH_OUT  (arith_out),
        .CARRY_OUT  (carry_out),
        .LOGIC_OUT  (logic_out),
        .CMP_OUT    (cmp_out),
        .SHIFT_OUT  (shift_out),
        .ARITH_FLAG (arith_flag),
        .LOGIC_FLAG (logic_flag),
        .CMP_FLAG   (cmp_flag),
        .SHIFT_FLAG (shift_flag)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the signed/unsigned values of the operands.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic [3:0] fun, input logic mrst);
        exp_t e;
        int sa;
        int sb;
        int ua;
        int ub;
        e = '{arith: '0, carry: 1'b0, logic_res: '0, cmp: '0, shift: '0, flags: '0};
        if (mrst)
            return e;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ua = int'(ma);
        ub = int'(mb);
        e.flags = 4'b0001 << (fun / 4);
        case (int'(fun))
            0:  begin e.arith = 32'(sa + sb); e.carry = (ua + ub) > 65535; end
            1:  begin e.arith = 32'(sa - sb); e.carry = ua < ub; end
            2:  e.arith = 32'(sa * sb);
            3:  e.arith = (sb == 0) ? 32'd0 : 32'(sa / sb);
            4:  e.logic_res = ma & mb;
            5:  e.logic_res = ma | mb;
            6:  e.logic_res = ~(ma & mb);
            7:  e.logic_res = ~(ma | mb);
            8:  e.cmp = 16'd0;
            9:  e.cmp = (sa == sb) ? 16'd1 : 16'd0;
            10: e.cmp = (sa > sb) ? 16'd2 : 16'd0;
            11: e.cmp = (sa < sb) ? 16'd3 : 16'd0;
            12: e.shift = 16'(ua / 2);
            13: e.shift = 16'((ua * 2) % 65536);
            14: e.shift = 16'(ub / 2);
            default: e.shift = 16'((ub * 2) % 65536);
        endcase
        return e;
    endfunction

    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkField({tag, " arith"}, arith_out, e.arith);
        checkField({tag, " carry"}, 32'(carry_out), 32'(e.carry));
        checkField({tag, " logic"}, 32'(logic_out), 32'(e.logic_res));
        checkField({tag, " cmp"},   32'(cmp_out), 32'(e.cmp));
        checkField({tag, " shift"}, 32'(shift_out), 32'(e.shift));
        checkField({tag, " flags"}, 32'({shift_flag, cmp_flag, logic_flag, arith_flag}), 32'(e.flags));
    endtask

    // Drive one operation, let one edge capture it, then check just after the edge.
    task automatic applyStimulus(input string tag, input logic [15:0] sa, input logic [15:0] sb,
                                 input logic [3:0] fun, input logic srst);
        exp_t e;
        rst     = srst;
        a       = sa;
        b       = sb;
        alu_fun = fun;
        e = model(sa, sb, fun, srst);
        @(posedge clk);
        #1;
        checkOutput(tag, e);
    endtask

    initial begin
        exp_t spot;
        rst = 1'b1; a = 16'h1234; b = 16'h5678; alu_fun = 4'd2;
        #2;

        applyStimulus("reset", 16'h1234, 16'h5678, 4'd2, 1'b1);
        applyStimulus("add_neg", 16'hFFEE, 16'hFFCE, 4'd0, 1'b0);
        spot = model(16'hFFEE, 16'hFFCE, 4'd0, 1'b0);
        checkField("add_spec_value", arith_out, 32'hFFFFFFBC);
        checkField("add_spec_model", spot.arith, 32'hFFFFFFBC);

        applyStimulus("sub", -16'sd5, -16'sd55, 4'd1, 1'b0);
        checkField("sub_spec", arith_out, 32'd50);
        applyStimulus("mul_pos", -16'sd5, -16'sd55, 4'd2, 1'b0);
        checkField("mul_spec", arith_out, 32'd275);
        applyStimulus("mul_neg", 16'sd5, -16'sd55, 4'd2, 1'b0);
        checkField("mul_neg_spec", arith_out, -32'sd275);
        applyStimulus("div_small", 16'sd5, -16'sd55, 4'd3, 1'b0);
        applyStimulus("div_neg", -16'sd55, 16'sd5, 4'd3, 1'b0);
        checkField("div_spec", arith_out, -32'sd11);
        applyStimulus("div_zero", 16'sd7, 16'sd0, 4'd3, 1'b0);
        applyStimulus("div_min", 16'h8000, 16'hFFFF, 4'd3, 1'b0);

        applyStimulus("and", 16'd25, 16'd94, 4'd4, 1'b0);
        checkField("and_spec", 32'(logic_out), 32'h0018);
        applyStimulus("or", 16'd25, 16'd94, 4'd5, 1'b0);
        applyStimulus("nand", 16'd25, 16'd94, 4'd6, 1'b0);
        checkField("nand_spec", 32'(logic_out), 32'hFFE7);
        applyStimulus("nor", 16'd25, 16'd94, 4'd7, 1'b0);

        applyStimulus("cmp_nop", 16'd25, 16'd94, 4'd8, 1'b0);
        applyStimulus("cmp_eq0", 16'd25, 16'd94, 4'd9, 1'b0);
        applyStimulus("cmp_gt0", 16'd25, 16'd94, 4'd10, 1'b0);
        applyStimulus("cmp_lt", 16'd25, 16'd94, 4'd11, 1'b0);
        applyStimulus("cmp_gt", 16'd94, 16'd30, 4'd10, 1'b0);
        applyStimulus("cmp_eq", 16'd100, 16'd100, 4'd9, 1'b0);
        applyStimulus("cmp_lt_signed", 16'hFFFF, 16'd1, 4'd11, 1'b0);
        checkField("cmp_signed_spec", 32'(cmp_out), 32'd3);

        applyStimulus("shr_a", 16'd25, 16'd94, 4'd12, 1'b0);
        applyStimulus("shl_a", 16'd25, 16'd94, 4'd13, 1'b0);
        applyStimulus("shr_b", 16'd25, 16'd94, 4'd14, 1'b0);
        applyStimulus("shl_b", 16'd25, 16'd94, 4'd15, 1'b0);
        checkField("shl_b_spec", 32'(shift_out), 32'd188);
        applyStimulus("shr_fill", 16'h8001, 16'd0, 4'd12, 1'b0);
        checkField("shr_fill_spec", 32'(shift_out), 32'h4000);
        applyStimulus("shl_drop", 16'h8001, 16'd0, 4'd13, 1'b0);

        applyStimulus("b2b_add", 16'd300, 16'hFF00, 4'd0, 1'b0);
        applyStimulus("b2b_or", 16'h0F0F, 16'h00FF, 4'd5, 1'b0);
        applyStimulus("b2b_gt", 16'd9, 16'd3, 4'd10, 1'b0);
        applyStimulus("b2b_rst", 16'd9, 16'd3, 4'd13, 1'b1);
        applyStimulus("b2b_mul", 16'd300, 16'd200, 4'd2, 1'b0);
        applyStimulus("b2b_shl", 16'd1, 16'hC003, 4'd15, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            applyStimulus("random", ra, rb, 4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
